// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with a direct-mapped tagged BTB for the fetch stage.
// Optional statistics counters are built only when BRANCH_PRED_STATS_EN is defined.
package common_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'd0,
    WEAK_NOT_TAKEN   = 2'd1,
    WEAK_TAKEN       = 2'd2,
    STRONG_TAKEN     = 2'd3
  } branch_pred_t;
endpackage

module branch_predictor_gshare
  import common_types_pkg::*;
#(
  parameter int PHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int HIST_W      = 4,
  localparam int IDXW       = $clog2(PHT_ENTRIES),
  localparam int BTBW       = $clog2(BTB_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     lookup_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  output logic            pred_hit,
  output logic [IDXW-1:0] pred_idx,
  input  logic            upd_valid,
  input  logic [31:0]     upd_pc,
  input  logic [IDXW-1:0] upd_idx,
  input  logic            upd_taken,
  input  logic [31:0]     upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispred
);
  localparam int TAGW = 32 - BTBW - 2;

  branch_pred_t    pht        [PHT_ENTRIES];
  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  word_t           btb_target [BTB_ENTRIES];

  logic [IDXW-1:0] hist_ext;
  logic [BTBW-1:0] lookup_line;
  logic [TAGW-1:0] lookup_tag;
  logic [BTBW-1:0] upd_line;
  logic [TAGW-1:0] upd_tag;
  branch_pred_t    pred_ctr;
  logic [1:0]      upd_ctr_cur;
  logic [1:0]      upd_ctr_next;

  // Global history lives in the low HIST_W bits of the index hash; width 0 means bimodal.
  if (HIST_W == 0) begin : g_no_hist
    assign hist_ext = '0;
  end else begin : g_hist
    logic [HIST_W-1:0] ghr;
    if (HIST_W == 1) begin : g_one
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst)            ghr <= '0;
        else if (upd_valid) ghr <= upd_taken;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst)            ghr <= '0;
        else if (upd_valid) ghr <= {ghr[HIST_W-2:0], upd_taken};
      end
    end
    always_comb begin
      // NOTE: default first so partial assignment cannot infer a latch.
      hist_ext = '0;
      hist_ext[HIST_W-1:0] = ghr;
    end
  end

  assign lookup_line = lookup_pc[BTBW+1:2];
  assign lookup_tag  = lookup_pc[31:BTBW+2];
  assign upd_line    = upd_pc[BTBW+1:2];
  assign upd_tag     = upd_pc[31:BTBW+2];

  assign pred_idx    = lookup_pc[IDXW+1:2] ^ hist_ext;
  assign pred_ctr    = pht[pred_idx];
  assign pred_hit    = btb_valid[lookup_line] && (btb_tag[lookup_line] == lookup_tag);
  assign pred_taken  = pred_hit && (pred_ctr == WEAK_TAKEN || pred_ctr == STRONG_TAKEN);
  assign pred_target = pred_taken ? btb_target[lookup_line] : lookup_pc + 32'd4;

  assign upd_ctr_cur = pht[upd_idx];
  always_comb begin
    upd_ctr_next = upd_ctr_cur;
    if (upd_taken && upd_ctr_cur != STRONG_TAKEN)           upd_ctr_next = upd_ctr_cur + 2'd1;
    else if (!upd_taken && upd_ctr_cur != STRONG_NOT_TAKEN) upd_ctr_next = upd_ctr_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= WEAK_NOT_TAKEN;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (upd_valid) begin
      pht[upd_idx] <= branch_pred_t'(upd_ctr_next);
      if (upd_taken) btb_valid[upd_line] <= 1'b1;
    end
  end

  // NOTE: tag/target storage is not reset; the valid bit alone qualifies it, so it can map to plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      btb_tag[upd_line]    <= upd_tag;
      btb_target[upd_line] <= upd_target;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (upd_valid) begin
      stat_updates <= stat_updates + 32'd1;
      if (upd_mispredict) stat_mispred <= stat_mispred + 32'd1;
    end
  end
  logic unused_bits;
  assign unused_bits = ^upd_pc[1:0];
`else
  assign stat_updates = '0;
  assign stat_mispred = '0;
  logic unused_bits;
  assign unused_bits = ^{upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: a bimodal instance (HIST_W=0) and a gshare instance (HIST_W=4) share lookup/update buses.
module tb_branch_predictor_gshare;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        upd_valid0, upd_valid4;
  logic [31:0] upd_pc;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic        pred_taken0, pred_hit0, pred_taken4, pred_hit4;
  logic [31:0] pred_target0, pred_target4;
  logic [5:0]  pred_idx0, pred_idx4;
  logic [31:0] stat_updates0, stat_mispred0, stat_updates4, stat_mispred4;

  int checks = 0;
  int failures = 0;

`ifdef BRANCH_PRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  branch_predictor_gshare #(.PHT_ENTRIES(64), .BTB_ENTRIES(16), .HIST_W(0)) dut0 (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken0), .pred_target(pred_target0), .pred_hit(pred_hit0), .pred_idx(pred_idx0),
    .upd_valid(upd_valid0), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_updates(stat_updates0), .stat_mispred(stat_mispred0)
  );

  branch_predictor_gshare #(.PHT_ENTRIES(64), .BTB_ENTRIES(16), .HIST_W(4)) dut4 (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken4), .pred_target(pred_target4), .pred_hit(pred_hit4), .pred_idx(pred_idx4),
    .upd_valid(upd_valid4), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_updates(stat_updates4), .stat_mispred(stat_mispred4)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  // One registered update; valids drop again 1ns after the edge.
  task automatic upd(input logic v0, input logic v4, input logic [31:0] pc, input logic [5:0] idx,
                     input logic taken, input logic [31:0] target, input logic mis);
    upd_valid0 = v0;  upd_valid4 = v4;
    upd_pc = pc;  upd_idx = idx;  upd_taken = taken;
    upd_target = target;  upd_mispredict = mis;
    @(posedge clk); #1;
    upd_valid0 = 1'b0;  upd_valid4 = 1'b0;  upd_mispredict = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  lookup_pc = '0;
    upd_valid0 = 1'b0;  upd_valid4 = 1'b0;  upd_pc = '0;  upd_idx = '0;
    upd_taken = 1'b0;  upd_target = '0;  upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    look(32'h100);
    check("rst_taken", 32'(pred_taken0), 32'd0);
    check("rst_hit", 32'(pred_hit0), 32'd0);
    check("rst_target", pred_target0, 32'h104);
    check("rst_idx0", 32'(pred_idx0), 32'h00);
    check("rst_idx4", 32'(pred_idx4), 32'h00);
    check("rst_stat_upd", stat_updates0, 32'd0);
    look(32'hFFFF_FFFC);
    check("wrap_target", pred_target0, 32'h0000_0000);
    check("wrap_idx", 32'(pred_idx0), 32'h3F);

    // Same-cycle lookup of an entry being updated sees the old state
    look(32'h100);
    upd_valid0 = 1'b1;  upd_pc = 32'h100;  upd_idx = 6'd0;
    upd_taken = 1'b1;  upd_target = 32'h200;  upd_mispredict = 1'b0;
    #1;
    check("nobypass_hit", 32'(pred_hit0), 32'd0);
    check("nobypass_target", pred_target0, 32'h104);
    @(posedge clk); #1;
    upd_valid0 = 1'b0;
    check("t2_hit", 32'(pred_hit0), 32'd1);
    check("t2_taken", 32'(pred_taken0), 32'd1);
    check("t2_target", pred_target0, 32'h200);

    // Hysteresis: saturate at strong-taken, one not-taken still predicts taken
    repeat (4) upd(1'b1, 1'b0, 32'h100, 6'd0, 1'b1, 32'h200, 1'b0);
    upd(1'b1, 1'b0, 32'h100, 6'd0, 1'b0, 32'h0, 1'b0);
    look(32'h100);
    check("t3_still_taken", 32'(pred_taken0), 32'd1);
    check("t3_still_target", pred_target0, 32'h200);
    repeat (2) upd(1'b1, 1'b0, 32'h100, 6'd0, 1'b0, 32'h0, 1'b0);
    look(32'h100);
    check("t3_not_taken", 32'(pred_taken0), 32'd0);
    check("t3_fallthrough", pred_target0, 32'h104);
    check("t3_hit_kept", 32'(pred_hit0), 32'd1);

    // BTB aliasing: 0x100 and 0x140 share line 0
    upd(1'b1, 1'b0, 32'h100, 6'h00, 1'b1, 32'h200, 1'b0);
    upd(1'b1, 1'b0, 32'h140, 6'h10, 1'b1, 32'h300, 1'b0);
    look(32'h100);
    check("t4_alias_evicted", 32'(pred_hit0), 32'd0);
    check("t4_alias_target", pred_target0, 32'h104);
    look(32'h140);
    check("t4_new_hit", 32'(pred_hit0), 32'd1);
    check("t4_new_target", pred_target0, 32'h300);

    // Global history T,T,N,T -> 4'b1101
    upd(1'b0, 1'b1, 32'h800, 6'd0, 1'b1, 32'h900, 1'b0);
    upd(1'b0, 1'b1, 32'h800, 6'd0, 1'b1, 32'h900, 1'b0);
    upd(1'b0, 1'b1, 32'h800, 6'd0, 1'b0, 32'h0, 1'b0);
    upd(1'b0, 1'b1, 32'h800, 6'd0, 1'b1, 32'h900, 1'b0);
    look(32'h0);
    check("t5_idx_pc0", 32'(pred_idx4), 32'h0D);
    look(32'h34);
    check("t5_idx_pc34", 32'(pred_idx4), 32'h00);
    check("t5_bimodal_idx", 32'(pred_idx0), 32'h0D);
    check("t5_stat_upd0", stat_updates0, STATS ? 32'd10 : 32'd0);
    check("t5_stat_upd4", stat_updates4, STATS ? 32'd4 : 32'd0);

    // Reset beats a same-cycle update
    rst = 1'b1;
    upd(1'b1, 1'b1, 32'h140, 6'h10, 1'b1, 32'h500, 1'b1);
    rst = 1'b0;
    look(32'h140);
    check("t6_hit_cleared", 32'(pred_hit0), 32'd0);
    check("t6_target", pred_target0, 32'h144);
    look(32'h0);
    check("t6_ghr_cleared", 32'(pred_idx4), 32'h00);
    check("t6_stat_upd", stat_updates0, 32'd0);
    check("t6_stat_mis", stat_mispred0, 32'd0);

    // Counter back to weak-not-taken: one taken update flips prediction
    upd(1'b1, 1'b0, 32'h140, 6'h10, 1'b1, 32'h500, 1'b0);
    upd(1'b1, 1'b0, 32'h100, 6'h00, 1'b0, 32'h0, 1'b1);
    upd(1'b1, 1'b0, 32'h180, 6'h20, 1'b0, 32'h0, 1'b0);
    look(32'h140);
    check("t6_retrain_taken", 32'(pred_taken0), 32'd1);
    check("t6_retrain_target", pred_target0, 32'h500);
    check("t6_stat_upd3", stat_updates0, STATS ? 32'd3 : 32'd0);
    check("t6_stat_mis1", stat_mispred0, STATS ? 32'd1 : 32'd0);
    check("t6_stat_upd4", stat_updates4, 32'd0);

    // Idle cycles change nothing
    repeat (3) @(posedge clk);
    #1;
    check("idle_target", pred_target0, 32'h500);
    check("idle_stat", stat_updates0, STATS ? 32'd3 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
